// File: rtl/mux_scan_controller_if.sv
// Signal bundle between the scan controller and the 4:1 multiplexer and its host.
// The slave modport is the controller's view; the master modport is the host/mux side.
interface mux_scan_controller_if;
   logic       start;
   logic [3:0] mask;
   logic [3:0] dwell;
   logic       F;
   logic       S1;
   logic       S0;
   logic [3:0] sample;
   logic       busy;
   logic       done;

   modport slave (
      input  start, mask, dwell, F,
      output S1, S0, sample, busy, done
   );

   modport master (
      output start, mask, dwell, F,
      input  S1, S0, sample, busy, done
   );
endinterface

// File: rtl/mux_scan_controller.sv
// Steps a 4:1 mux select through the enabled channels in ascending order,
// waits a settle time on each, then captures the mux output per channel.
module mux_scan_controller (
   input  logic                  clk,
   input  logic                  rst,
   mux_scan_controller_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

   state_t     state, state_n;
   logic [3:0] mask_q, mask_n;
   logic [3:0] dwell_q, dwell_n;
   logic [3:0] cnt, cnt_n;
   logic [1:0] sel, sel_n;
   logic [3:0] sample_q, sample_n;
   logic       busy_q, busy_n;
   logic       done_q, done_n;
   logic [3:0] dwell_eff;
   logic [2:0] first_ch, next_ch;

   // Returns {found, index} of the lowest set bit of m at or above position from.
   function automatic logic [2:0] pick_ch(input logic [3:0] m, input logic [2:0] from);
      logic [2:0] r;
      r = '0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   assign dwell_eff = (bus.dwell == 4'd0) ? 4'd1 : bus.dwell;
   assign first_ch  = pick_ch(bus.mask, 3'd0);
   assign next_ch   = pick_ch(mask_q, {1'b0, sel} + 3'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mask_q   <= '0;
         dwell_q  <= '0;
         cnt      <= '0;
         sel      <= '0;
         sample_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         mask_q   <= mask_n;
         dwell_q  <= dwell_n;
         cnt      <= cnt_n;
         sel      <= sel_n;
         sample_q <= sample_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      mask_n   = mask_q;
      dwell_n  = dwell_q;
      cnt_n    = cnt;
      sel_n    = sel;
      sample_n = sample_q;
      busy_n   = busy_q;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               mask_n   = bus.mask;
               sample_n = '0;
               if (bus.mask == 4'd0) begin
                  // Empty scan: report completion without touching the select.
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  dwell_n = dwell_eff;
                  cnt_n   = dwell_eff;
                  sel_n   = first_ch[1:0];
                  busy_n  = 1'b1;
                  state_n = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt <= 4'd1) state_n = CAPTURE;
            else             cnt_n   = cnt - 4'd1;
         end
         CAPTURE: begin
            sample_n[sel] = bus.F;
            if (next_ch[2]) begin
               sel_n   = next_ch[1:0];
               cnt_n   = dwell_q;
               state_n = SETTLE;
            end else begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.S1     = sel[1];
   assign bus.S0     = sel[0];
   assign bus.sample = sample_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: table vectors, hand-written corner sequences and
// random scans, all checked cycle by cycle against a trace built from the scan rules.
module tb_mux_scan_controller;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] w;

   always #5 clk = ~clk;

   mux_scan_controller_if bus();
   assign bus.F = w[{bus.S1, bus.S0}];

   mux_scan_controller dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [1:0] s;
      logic       busy;
      logic       done;
      logic [3:0] sample;
   } obs_t;

   typedef struct {
      logic [3:0] w;
      logic [3:0] mask;
      logic [3:0] dwell;
      logic [3:0] exp_sample;
      int         exp_done;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   logic [1:0] model_s;
   obs_t exp_q[$];
   vec_t tbl[6];

   function automatic obs_t observe();
      return {bus.S1, bus.S0, bus.busy, bus.done, bus.sample};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected per-cycle outputs: each enabled channel is selected for D settle cycles
   // plus one capture cycle, its bit appears after capture, then a single done cycle.
   task automatic build_trace(input logic [3:0] wv, input logic [3:0] m, input logic [3:0] d);
      int dd;
      logic [3:0] acc;
      dd  = (d == 0) ? 1 : int'(d);
      acc = '0;
      exp_q.delete();
      for (int ch = 0; ch < 4; ch++) begin
         if (m[ch]) begin
            for (int c = 0; c <= dd; c++) exp_q.push_back({2'(ch), 1'b1, 1'b0, acc});
            acc[ch] = wv[ch];
            model_s = 2'(ch);
         end
      end
      exp_q.push_back({model_s, 1'b0, 1'b1, acc});
   endtask

   // Entered just after a negedge; returns the cycle index in which done was seen.
   task automatic run_scan(input logic [3:0] wv, input logic [3:0] m, input logic [3:0] d,
                           input bit hold, input bit mid_change, output int done_cyc);
      obs_t o;
      obs_t last;
      w         = wv;
      bus.start = 1'b1;
      bus.mask  = m;
      bus.dwell = d;
      build_trace(wv, m, d);
      last = exp_q[exp_q.size() - 1];
      done_cyc = 0;
      @(posedge clk);
      for (int k = 1; k <= exp_q.size(); k++) begin
         @(negedge clk);
         o = observe();
         check("trace", 32'(o), 32'(exp_q[k-1]));
         if (o.done && done_cyc == 0) done_cyc = k;
         if (k == 1) begin
            if (!hold) bus.start = 1'b0;
            if (mid_change) begin
               bus.mask  = 4'b0001;
               bus.dwell = 4'd5;
            end
         end
      end
      @(negedge clk);
      check("idle_after", 32'(observe()), 32'({last.s, 1'b0, 1'b0, last.sample}));
   endtask

   initial begin
      int dc;
      logic [3:0] rw, rm, rd;

      tbl[0] = '{w:4'b1010, mask:4'b0000, dwell:4'd2, exp_sample:4'b0000, exp_done:1};
      tbl[1] = '{w:4'b1010, mask:4'b1111, dwell:4'd2, exp_sample:4'b1010, exp_done:13};
      tbl[2] = '{w:4'b1111, mask:4'b0101, dwell:4'd0, exp_sample:4'b0101, exp_done:5};
      tbl[3] = '{w:4'b0110, mask:4'b1000, dwell:4'd1, exp_sample:4'b0000, exp_done:3};
      tbl[4] = '{w:4'b1001, mask:4'b1001, dwell:4'd4, exp_sample:4'b1001, exp_done:11};
      tbl[5] = '{w:4'b0111, mask:4'b0110, dwell:4'd15, exp_sample:4'b0110, exp_done:33};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.mask  = '0;
      bus.dwell = '0;
      w = '0;
      model_s = 2'd0;
      #1;
      check("reset_state", 32'(observe()), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_scan(tbl[i].w, tbl[i].mask, tbl[i].dwell, 1'b0, 1'b0, dc);
         check($sformatf("done_cycle[%0d]", i), 32'(dc), 32'(tbl[i].exp_done));
         check($sformatf("sample[%0d]", i), 32'(bus.sample), 32'(tbl[i].exp_sample));
      end

      // Asynchronous reset in the middle of channel 2's settle window.
      w = 4'($urandom);
      bus.start = 1'b1;
      bus.mask  = 4'b1111;
      bus.dwell = 4'd3;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_sel", 32'({bus.S1, bus.S0, bus.busy}), 32'({2'd2, 1'b1}));
      #1 rst = 1'b1;
      #1 check("async_rst", 32'(observe()), 32'h0);
      dc = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) dc++;
      end
      check("no_done_in_rst", 32'(dc), 32'd0);
      rst = 1'b0;
      model_s = 2'd0;
      @(negedge clk);
      check("idle_after_rst", 32'(observe()), 32'h0);
      run_scan(4'b0101, 4'b1111, 4'd3, 1'b0, 1'b0, dc);
      check("rescan_done", 32'(dc), 32'd17);

      // start held high: back-to-back scans, each accepted only from IDLE.
      run_scan(4'b1000, 4'b1000, 4'd1, 1'b1, 1'b0, dc);
      check("hold_done1", 32'(dc), 32'd3);
      run_scan(4'b1000, 4'b1000, 4'd1, 1'b1, 1'b0, dc);
      check("hold_done2", 32'(dc), 32'd3);
      bus.start = 1'b0;
      @(negedge clk);
      check("hold_released", 32'({bus.busy, bus.done}), 32'd0);

      // mask/dwell changes after acceptance must not affect the running scan.
      run_scan(4'b1000, 4'b1000, 4'd1, 1'b0, 1'b1, dc);
      check("midchange_done", 32'(dc), 32'd3);
      check("midchange_sample", 32'(bus.sample), 32'(4'b1000));

      for (int r = 0; r < 25; r++) begin
         rw = 4'($urandom);
         rm = 4'($urandom);
         rd = 4'($urandom_range(0, 6));
         run_scan(rw, rm, rd, 1'b0, 1'b0, dc);
         check("rand_sample", 32'(bus.sample), 32'(rw & rm));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mux_scan_controller.md
MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the remaining ports SHALL be exactly those below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  scan request, sampled only in IDLE.
REQ-005 mask  input  4  channel enable; bit i enables channel i (W0..W3); latched on accepted start.
REQ-006 dwell  input  4  settle cycles per channel; latched on accepted start; 0 treated as 1.
REQ-007 F  input  1  output of the downstream 4:1 multiplexer, combinational from S1/S0.
REQ-008 S1  output  1  multiplexer select MSB, registered.
REQ-009 S0  output  1  multiplexer select LSB, registered.
REQ-010 sample  output  4  captured F value per channel; bit i is the value read while {S1,S0}=i.
REQ-011 busy  output  1  high in SETTLE and CAPTURE.
REQ-012 done  output  1  one-cycle pulse when a scan completes.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, CAPTURE and DONE; all outputs SHALL be registered.
REQ-014 IDLE: start=1 at a clock edge -> latch mask and dwell, clear sample to 4'b0000, load the settle counter with max(dwell,1), set {S1,S0} to the lowest enabled channel, go to SETTLE.
REQ-015 IDLE with start=1 and mask=4'b0000 -> go directly to DONE, sample=4'b0000, {S1,S0} unchanged.
REQ-016 SETTLE SHALL last exactly max(dwell,1) cycles with {S1,S0} held constant, then go to CAPTURE.
REQ-017 CAPTURE SHALL last 1 cycle; at the edge leaving CAPTURE, sample[{S1,S0}] <= F.
REQ-018 After CAPTURE, if a higher-numbered enabled channel exists, {S1,S0} SHALL advance to the next enabled channel in ascending order, reload the counter, and return to SETTLE; otherwise go to DONE.
REQ-019 Channels SHALL never wrap: a scan visits each enabled channel exactly once, from channel 0 to channel 3.
REQ-020 Disabled channels SHALL never be selected and their sample bits SHALL read 0 after the scan.
REQ-021 DONE SHALL last 1 cycle with done=1, then go to IDLE; sample and {S1,S0} SHALL hold until the next accepted start.
REQ-022 start asserted in SETTLE, CAPTURE or DONE SHALL be ignored (not queued); changes to mask or dwell after acceptance SHALL have no effect.
REQ-023 Latency: for N enabled channels and D=max(dwell,1), done SHALL be high in cycle N*(D+1)+1 after the accepting edge (cycle 1 for N=0).

Reset
REQ-024 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, S1=0, S0=0, sample=4'b0000, busy=0, done=0, counter=0.
REQ-025 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first start after rst deasserts SHALL begin a fresh scan.

Verification (bench models F = W[{S1,S0}] combinationally)
REQ-026 W3..W0=4'b1010, mask=4'b1111, dwell=2, start pulse -> S sequence 0,1,2,3 (3 cycles each), done in cycle 13, sample=4'b1010, busy=1 for cycles 1..12.
REQ-027 W=4'b1111, mask=4'b0101, dwell=0 -> only channels 0 and 2 selected, 2 cycles each, done in cycle 5, sample=4'b0101.
REQ-028 mask=4'b0000, start -> done in cycle 1, busy never 1, sample=4'b0000, S1=S0=0.
REQ-029 mask=4'b1111, dwell=3, rst asserted in channel 2 SETTLE between edges -> S1=S0=0, busy=0, sample=0 immediately, no done; a new start then completes normally.
REQ-030 start held high across a whole scan (mask=4'b1000, dwell=1) -> exactly one done per visit to IDLE, with a new scan accepted only in IDLE; mask changed mid-scan to 4'b0001 -> current scan still selects only channel 3.
